// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared defaults, FSM state type and level-width helper for hs_sink
package hs_pkg;

  localparam int HS_DATA_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_e;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit over the address width.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_sink_fifo.sv
// rtl/hs_sink_fifo.sv - show-ahead synchronous FIFO with registered occupancy
module hs_sink_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_en, pop_en;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign level   = level_q;
  // Head is forced to zero when empty so the reset value is defined without clearing memory.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hs_sink.sv
// rtl/hs_sink.sv - 4-phase handshake receiver feeding a valid/ready FIFO; HS_SINK_SYNC2_EN selects a two-flop request synchronizer
module hs_sink
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      hs_req,
  input  logic [DATA_W-1:0]         hs_data,
  output logic                      hs_ack,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  hs_state_e state_q, state_d;
  logic      req_s_q;
  logic      push, pop;
  logic      full, empty;

`ifdef HS_SINK_SYNC2_EN
  logic req_meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= hs_req;
      req_s_q    <= req_meta_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) req_s_q <= 1'b0;
    else     req_s_q <= hs_req;
  end
`endif

  // Full is judged on registered occupancy, so a pop frees room only from the next cycle.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s_q && !full) begin
          state_d = ACK;
          push    = 1'b1;
        end
      end
      ACK: begin
        if (!req_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign hs_ack    = (state_q == ACK);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  hs_sink_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (hs_data),
    .dout  (out_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_hs_sink.sv
// tb/tb_hs_sink.sv - scoreboard bench for hs_sink: latency, backpressure, streaming and reset cases
module tb_hs_sink;

`ifdef HS_SINK_SYNC2_EN
  localparam int SYNC_LAT = 3;
`else
  localparam int SYNC_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs_req = 1'b0;
  logic [2:0] hs_data = '0;
  logic       hs_ack;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_data;
  logic [2:0] level;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] exp_q[$];
  bit         track_lvl = 1'b0;
  int         max_lvl = 0;

  hs_sink #(.DATA_W(3), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .hs_req    (hs_req),
    .hs_data   (hs_data),
    .hs_ack    (hs_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic v, input string name);
    int k = 0;
    while (hs_ack !== v && k < 100) begin
      tick();
      k++;
    end
    check(name, 32'(hs_ack), 32'(v));
  endtask

  task automatic send(input logic [2:0] d);
    exp_q.push_back(d);
    hs_data = d;
    hs_req  = 1'b1;
    wait_ack(1'b1, "ack_rise");
    hs_req = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (out_valid && k < 20) begin
      tick();
      k++;
    end
    check("drain_empty", 32'(out_valid), 32'd0);
  endtask

  // Monitor: every accepted output token is compared against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (track_lvl && int'(level) > max_lvl) max_lvl = int'(level);
      if (!rst && out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %0d expected none", out_data);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL out_data: got %0d expected %0d", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(2);
    rst = 1'b0;
    check("rst_ack", 32'(hs_ack), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // Request-to-ack latency, both edges, single token.
    exp_q.push_back(3'd5);
    hs_data = 3'b101;
    hs_req  = 1'b1;
    tick(SYNC_LAT - 1);
    check("lat_ack_early", 32'(hs_ack), 32'd0);
    tick();
    check("lat_ack", 32'(hs_ack), 32'd1);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_data", 32'(out_data), 32'd5);
    check("lat_level", 32'(level), 32'd1);
    hs_req = 1'b0;
    tick(SYNC_LAT - 1);
    check("fall_ack_early", 32'(hs_ack), 32'd1);
    tick();
    check("fall_ack", 32'(hs_ack), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_level", 32'(level), 32'd0);

    // Fill to DEPTH, fifth request must stall until a pop frees an entry.
    for (int i = 1; i <= 4; i++) send(3'(i));
    check("full_level", 32'(level), 32'd4);
    exp_q.push_back(3'd5);
    hs_data = 3'd5;
    hs_req  = 1'b1;
    tick(10);
    check("bp_ack", 32'(hs_ack), 32'd0);
    check("bp_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_at_full_level", 32'(level), 32'd3);
    check("pop_at_full_ack", 32'(hs_ack), 32'd0);
    tick();
    check("late_push_ack", 32'(hs_ack), 32'd1);
    check("late_push_level", 32'(level), 32'd4);
    hs_req = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");
    drain();

    // Streaming with the consumer always ready.
    out_ready = 1'b1;
    max_lvl   = 0;
    track_lvl = 1'b1;
    send(3'd6);
    send(3'd7);
    send(3'd0);
    send(3'd3);
    send(3'd2);
    tick(2);
    track_lvl = 1'b0;
    check("stream_max_level", 32'(max_lvl), 32'd1);
    check("stream_level", 32'(level), 32'd0);

    // Reset in the middle of a handshake with two tokens stored.
    out_ready = 1'b0;
    send(3'd1);
    exp_q.push_back(3'd6);
    hs_data = 3'd6;
    hs_req  = 1'b1;
    wait_ack(1'b1, "mid_ack");
    check("mid_level", 32'(level), 32'd2);
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ack", 32'(hs_ack), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(3'd6);
    wait_ack(1'b1, "reaccept_ack");
    check("reaccept_level", 32'(level), 32'd1);
    check("reaccept_data", 32'(out_data), 32'd6);
    hs_req = 1'b0;
    wait_ack(1'b0, "reaccept_fall");
    drain();

    tick(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_sink.md
HS_SINK -- requirements
Module: hs_sink

Interface
REQ-001 SHALL have parameter DATA_W, default 3, token data width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-005 SHALL have port hs_req, input, 1, 4-phase request from the upstream handshake stage (asynchronous to clk).
REQ-006 SHALL have port hs_data, input, DATA_W, bundled data; the upstream stage holds it stable while hs_req=1.
REQ-007 SHALL have port hs_ack, output, 1, 4-phase acknowledge to the upstream stage, registered.
REQ-008 SHALL have port out_valid, output, 1, high when the FIFO is non-empty.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts out_data when out_valid=1.
REQ-010 SHALL have port out_data, output, DATA_W, FIFO head (show-ahead).
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1, current FIFO occupancy.

Function
REQ-012 SHALL bring hs_req into the clk domain as req_s; the synchronizer depth is set by REQ-027/028.
REQ-013 SHALL implement FSM states IDLE (hs_ack=0) and ACK (hs_ack=1).
REQ-014 IDLE -> ACK SHALL occur when req_s=1 and level<DEPTH; on that same edge, hs_data is pushed into the FIFO and hs_ack is set to 1.
REQ-015 IDLE with req_s=1 and level=DEPTH SHALL hold IDLE with hs_ack=0 (backpressure) until a pop frees an entry.
REQ-016 ACK -> IDLE SHALL occur when req_s=0, clearing hs_ack on that edge; while req_s=1, the FSM SHALL remain in ACK with no further push.
REQ-017 SHALL pop when out_valid=1 and out_ready=1; out_data then advances to the next entry on the following cycle.
REQ-018 The full test in REQ-014 SHALL use the registered level, so a same-cycle pop does not enable a push at full; the push is taken one cycle later.
REQ-019 A simultaneous push and pop SHALL leave level unchanged and pass data in order.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 Tokens SHALL leave in arrival order, with no loss or duplication, outside reset.

Reset
REQ-023 With rst=1 at a clk edge, the block SHALL enter state IDLE with hs_ack=0, out_valid=0, level=0, out_data=0, pointers=0 and synchronizer flops=0.
REQ-024 Reset mid-handshake SHALL drop hs_ack and discard the FIFO contents.
REQ-025 If hs_req is still high after a mid-handshake reset, that token SHALL be accepted again; upstream resets together with this block.
REQ-026 Reset SHALL have priority over push and pop.

Configuration
REQ-027 With HS_SINK_SYNC2_EN defined, req_s SHALL come from a two-flop synchronizer, so that hs_req rise -> hs_ack rise is 3 clk edges.
REQ-028 Without HS_SINK_SYNC2_EN, req_s SHALL be a single register of hs_req (hs_req rise -> hs_ack rise is 2 edges), for simulation or same-domain use only.

Structure
REQ-029 Package hs_pkg SHALL hold the DATA_W default, the FSM state enum (IDLE, ACK) and the level-width function.
REQ-030 The FIFO SHALL be a sub-module hs_sink_fifo (push, pop, din, dout, level, full, empty); the FSM and synchronizer remain in hs_sink.

Verification
REQ-031 SYNC2_EN: rst, then hs_req=1, hs_data=3'b101 -> hs_ack=1 on the 3rd edge; out_valid=1, out_data=5, level=1; hs_req=0 -> hs_ack=0 3 edges later.
REQ-032 Five 4-phase tokens 1,2,3,4,5 with out_ready=0, DEPTH=4 -> four acks, level=4; the 5th hs_req is left unacked; one pop -> 5th acked 2 edges after the pop (SYNC2 path); output order 1,2,3,4,5.
REQ-033 Continuous handshakes with out_ready=1 -> each token is pushed and popped with level never above 1; out_data sequence equals input sequence.
REQ-034 rst pulsed while in ACK with level=2 -> next cycle hs_ack=0, level=0, out_valid=0; hs_req still high -> the token is re-accepted.
REQ-035 Level=4, out_ready=1 and req_s=1 in the same cycle -> pop occurs, level=3, no push that cycle; push occurs the next cycle, giving level=4.
REQ-036 Without HS_SINK_SYNC2_EN: hs_req rise -> hs_ack rise after exactly 2 edges.
